// File: rtl/warp_ibuffer_pkg.sv
// Shared configuration and derived widths for the warp instruction buffer.
package warp_ibuffer_pkg;

  localparam int unsigned NUM_WARPS = 4;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned DATAW     = 64;

  localparam int unsigned NW_BITS  = $clog2(NUM_WARPS);
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1);
  localparam int unsigned PTR_BITS = $clog2(DEPTH);

endpackage

// File: rtl/warp_rr_arbiter.sv
// Round-robin pick of one requesting warp, searching upward from rr_ptr with wrap.
module warp_rr_arbiter
  import warp_ibuffer_pkg::*;
(
  input  logic [NUM_WARPS-1:0] req,
  input  logic [NW_BITS-1:0]   rr_ptr,
  output logic [NUM_WARPS-1:0] grant_c,
  output logic [NW_BITS-1:0]   grant_idx_c,
  output logic                 grant_any_c
);

  logic                 found;
  logic [NUM_WARPS-1:0] grant;
  logic [NW_BITS-1:0]   idx;
  int unsigned          k;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    k     = 0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      k = (int'(rr_ptr) + i) % NUM_WARPS;
      if (!found && req[NW_BITS'(k)]) begin
        found               = 1'b1;
        idx                 = NW_BITS'(k);
        grant[NW_BITS'(k)]  = 1'b1;
      end
    end
    grant_c     = grant;
    grant_idx_c = idx;
    grant_any_c = found;
  end

endmodule

// File: rtl/warp_ibuffer.sv
// Per-warp instruction FIFOs feeding a round-robin arbitrated, registered valid/ready output.
module warp_ibuffer
  import warp_ibuffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [NW_BITS-1:0]   in_wid,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [NW_BITS-1:0]   out_wid,
  output logic [DATAW-1:0]     out_data,
  input  logic                 out_ready,
  output logic [NUM_WARPS-1:0] ibuf_pop,
  output logic [NUM_WARPS-1:0] empty_mask,
  output logic [NUM_WARPS-1:0] full_mask
);

  logic [DATAW-1:0]    mem    [NUM_WARPS][DEPTH];
  logic [PTR_BITS-1:0] rd_ptr [NUM_WARPS];
  logic [PTR_BITS-1:0] wr_ptr [NUM_WARPS];
  logic [CNT_BITS-1:0] cnt    [NUM_WARPS];
  logic [NW_BITS-1:0]  rr_ptr;

  logic                 in_fire_c;
  logic                 load_en_c;
  logic                 deq_any_c;
  logic [NUM_WARPS-1:0] enq_c;
  logic [NUM_WARPS-1:0] deq_c;
  logic [NUM_WARPS-1:0] grant_c;
  logic [NW_BITS-1:0]   grant_idx_c;
  logic                 grant_any_c;

  // Masks come from registered counts only, so a same-cycle enqueue is never a candidate.
  always_comb begin
    empty_mask = '0;
    full_mask  = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      empty_mask[w] = (cnt[w] == '0);
      full_mask[w]  = (cnt[w] == CNT_BITS'(DEPTH));
    end
  end

  assign in_ready  = ~full_mask[in_wid];
  assign in_fire_c = in_valid & in_ready;
  assign load_en_c = ~out_valid | out_ready;
  assign deq_any_c = load_en_c & grant_any_c;

  always_comb begin
    enq_c = '0;
    if (in_fire_c) enq_c[in_wid] = 1'b1;
    deq_c = deq_any_c ? grant_c : '0;
  end

  warp_rr_arbiter u_arb (
    .req         (~empty_mask),
    .rr_ptr      (rr_ptr),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c),
    .grant_any_c (grant_any_c)
  );

  // Payload storage carries no reset; validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    if (in_fire_c) mem[in_wid][wr_ptr[in_wid]] <= in_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        cnt[w]    <= '0;
        rd_ptr[w] <= '0;
        wr_ptr[w] <= '0;
      end
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_wid   <= '0;
      out_data  <= '0;
      ibuf_pop  <= '0;
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        if (enq_c[w]) wr_ptr[w] <= wr_ptr[w] + PTR_BITS'(1);
        if (deq_c[w]) rd_ptr[w] <= rd_ptr[w] + PTR_BITS'(1);
        if (enq_c[w] && !deq_c[w])      cnt[w] <= cnt[w] + CNT_BITS'(1);
        else if (!enq_c[w] && deq_c[w]) cnt[w] <= cnt[w] - CNT_BITS'(1);
      end
      ibuf_pop <= deq_c;
      if (deq_any_c) begin
        out_valid <= 1'b1;
        out_wid   <= grant_idx_c;
        out_data  <= mem[grant_idx_c][rd_ptr[grant_idx_c]];
        rr_ptr    <= (grant_idx_c == NW_BITS'(NUM_WARPS - 1)) ? '0 : grant_idx_c + NW_BITS'(1);
      end else if (load_en_c) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_warp_ibuffer.sv
// Self-checking bench for warp_ibuffer: vector table, directed corner cases, per-warp scoreboard.
module tb_warp_ibuffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_wid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [1:0]  out_wid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [3:0]  ibuf_pop;
  logic [3:0]  empty_mask;
  logic [3:0]  full_mask;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q [4][$];
  int          hs_count [4];
  logic        prev_load;

  typedef struct {
    logic [1:0]  wid;
    logic [63:0] data;
    logic [1:0]  exp_wid;
    logic [3:0]  exp_pop;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  warp_ibuffer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_wid     (in_wid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_wid    (out_wid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .ibuf_pop   (ibuf_pop),
    .empty_mask (empty_mask),
    .full_mask  (full_mask)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input int w, input logic [63:0] d);
    in_valid = 1'b1;
    in_wid   = 2'(w);
    in_data  = d;
    chk("enq_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c;
    out_ready = 1'b1;
    c = 0;
    while (c < 64 && !(out_valid == 1'b0 && empty_mask == 4'hF)) begin
      tick();
      c++;
    end
    chk("drain_done", 64'({out_valid, empty_mask}), 64'h0F);
    chk("sb_empty", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 64'd0);
  endtask

  // Scoreboard and pop monitor, sampled on the falling edge.
  initial begin
    logic [3:0]  exp_pop;
    logic [63:0] exp_d;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        prev_load = 1'b0;
      end else begin
        exp_pop = (prev_load && out_valid) ? (4'b0001 << out_wid) : 4'b0000;
        chk("ibuf_pop", 64'(ibuf_pop), 64'(exp_pop));
        if (in_valid && in_ready) exp_q[in_wid].push_back(in_data);
        if (out_valid && out_ready) begin
          if (exp_q[out_wid].size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_underflow: output wid %0d data %h with no expected entry", out_wid, out_data);
          end else begin
            exp_d = exp_q[out_wid].pop_front();
            chk("sb_data", out_data, exp_d);
            hs_count[out_wid]++;
          end
        end
        prev_load = !out_valid || out_ready;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_seq [6];
    rr_seq[0] = 2'd0; rr_seq[1] = 2'd1; rr_seq[2] = 2'd3;
    rr_seq[3] = 2'd0; rr_seq[4] = 2'd1; rr_seq[5] = 2'd3;
    vecs[0] = '{wid: 2'd2, data: 64'h00000000000000A5, exp_wid: 2'd2, exp_pop: 4'b0100};
    vecs[1] = '{wid: 2'd0, data: 64'h123456789ABCDEF0, exp_wid: 2'd0, exp_pop: 4'b0001};
    vecs[2] = '{wid: 2'd3, data: 64'hFFFFFFFFFFFFFFFF, exp_wid: 2'd3, exp_pop: 4'b1000};
    vecs[3] = '{wid: 2'd1, data: 64'h5A5A0000C3C3_0001, exp_wid: 2'd1, exp_pop: 4'b0010};
    for (int i = 0; i < 4; i++) hs_count[i] = 0;

    reset = 1'b1; in_valid = 1'b0; in_wid = '0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_wid", 64'(out_wid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_empty", 64'(empty_mask), 64'hF);
    chk("rst_full", 64'(full_mask), 64'h0);
    chk("rst_pop", 64'(ibuf_pop), 64'h0);
    reset = 1'b0;
    tick();

    // Reset arriving mid-stream discards everything.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) enq(1, 64'h1110 + 64'(i));
    chk("t1_loaded", 64'(out_valid), 64'd1);
    reset = 1'b1;
    #1;
    chk("t1_rst_valid", 64'(out_valid), 64'd0);
    chk("t1_rst_empty", 64'(empty_mask), 64'hF);
    chk("t1_rst_pop", 64'(ibuf_pop), 64'h0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_no_out", 64'(out_valid), 64'd0);
      chk("t1_no_pop", 64'(ibuf_pop), 64'h0);
    end

    // Single-entry latency table.
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      enq(int'(vecs[i].wid), vecs[i].data);
      chk("lat_not_early", 64'(out_valid), 64'd0);
      tick();
      chk("lat_valid", 64'(out_valid), 64'd1);
      chk("lat_wid", 64'(out_wid), 64'(vecs[i].exp_wid));
      chk("lat_data", out_data, vecs[i].data);
      chk("lat_pop", 64'(ibuf_pop), 64'(vecs[i].exp_pop));
      tick();
      chk("lat_consumed", 64'(out_valid), 64'd0);
    end

    // Full FIFO with the output register stalled.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) enq(0, 64'hF000 + 64'(i));
    chk("t3_full", 64'(full_mask), 64'b0001);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_out_data", out_data, 64'hF000);
    in_wid = 2'd0;
    #1;
    chk("t3_ready_w0", 64'(in_ready), 64'd0);
    in_wid = 2'd3;
    #1;
    chk("t3_ready_w3", 64'(in_ready), 64'd1);
    drain();

    // Round robin across warps 0, 1 and 3.
    out_ready = 1'b0;
    enq(0, 64'hA0); enq(0, 64'hA1); enq(1, 64'hB0);
    enq(1, 64'hB1); enq(3, 64'hD0); enq(3, 64'hD1);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("rr_valid", 64'(out_valid), 64'd1);
      chk("rr_wid", 64'(out_wid), 64'(rr_seq[i]));
      tick();
    end
    chk("rr_done", 64'(out_valid), 64'd0);
    drain();

    // Backpressure hold while new entries arrive.
    out_ready = 1'b0;
    enq(2, 64'hCAFE);
    tick();
    chk("bp_load_wid", 64'(out_wid), 64'd2);
    chk("bp_load_pop", 64'(ibuf_pop), 64'b0100);
    for (int i = 0; i < 5; i++) begin
      enq((i == 4) ? 2 : (i % 2), 64'hBB00 + 64'(i));
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_wid", 64'(out_wid), 64'd2);
      chk("bp_data", out_data, 64'hCAFE);
      chk("bp_pop", 64'(ibuf_pop), 64'h0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_next_valid", 64'(out_valid), 64'd1);
    chk("bp_next_wid", 64'(out_wid), 64'd0);
    chk("bp_next_pop", 64'(ibuf_pop), 64'b0001);
    drain();

    // Back-to-back on warp 3 exercises pointer wrap with simultaneous push/pop.
    hs_count[3] = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("w3_not_full", 64'(full_mask[3]), 64'd0);
      chk("w3_cnt_le2", 64'(dut.cnt[3] <= 3'd2), 64'd1);
      enq(3, 64'h3300 + 64'(i));
    end
    drain();
    chk("w3_count", 64'(hs_count[3]), 64'd10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
